// File: rtl/sqrt_pkg.sv
// Shared types and constants for the root-to-BCD display block.
// Holds the controller state type and the 7-segment glyph table.
package sqrt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment pattern.
// seg[0]=a .. seg[6]=g.
module bcd_to_seg7
    import sqrt_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (nib_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/sqrt_bcd_display.sv
// Converts an 8-bit root to BCD by shift-add-3 and drives a
// 3-digit multiplexed 7-segment display with leading-zero blanking.
module sqrt_bcd_display
    import sqrt_pkg::*;
#(
    parameter int REFRESH_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  dig_en
);

    state_e               state_q, state_d;
    logic [7:0]           bin_q, bin_d;
    logic [11:0]          work_q, work_d;
    logic [11:0]          bcd_q, bcd_d;
    logic [2:0]           step_q, step_d;
    logic [REFRESH_W-1:0] ref_q;
    logic [1:0]           idx_q, idx_d;

    logic [11:0] adj;
    logic [19:0] shifted;
    logic [3:0]  nib;
    logic        blank;
    logic [6:0]  pat;

    assign adj = {add3(work_q[11:8]),
                  add3(work_q[7:4]),
                  add3(work_q[3:0])};
    assign shifted = {adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        step_d  = step_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = in_data;
                    work_d  = 12'h000;
                    step_d  = 3'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                work_d = shifted[19:8];
                bin_d  = shifted[7:0];
                step_d = step_q + 3'd1;
                // Last step publishes straight from the shifter.
                if (step_q == 3'd7) begin
                    bcd_d   = shifted[19:8];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= 8'h00;
            work_q  <= 12'h000;
            step_q  <= 3'd0;
            bcd_q   <= 12'h000;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            step_q  <= step_d;
            bcd_q   <= bcd_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == CONV);
    assign bcd      = bcd_q;

    always_comb begin
        idx_d = idx_q;
        if (&ref_q) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q <= '0;
            idx_q <= 2'd0;
        end else begin
            ref_q <= ref_q + 1'b1;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        nib   = bcd_q[3:0];
        blank = 1'b0;
        case (idx_q)
            2'd1: begin
                nib   = bcd_q[7:4];
                blank = (bcd_q[11:4] == 8'h00);
            end
            2'd2: begin
                nib   = bcd_q[11:8];
                blank = (bcd_q[11:8] == 4'h0);
            end
            default: begin
                nib   = bcd_q[3:0];
                blank = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_seg (
        .nib_i (nib),
        .seg_o (pat)
    );

    assign seg    = blank ? 7'h00 : pat;
    assign dig_en = blank ? 3'b000 : (3'b001 << idx_q);

endmodule

// File: tb/tb_sqrt_bcd_display.sv
// Directed bench for sqrt_bcd_display with a 4-cycle digit slot.
// Vector table plus hand sequences for back-to-back, abort and refresh.
module tb_sqrt_bcd_display;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        busy;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  dig_en;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [11:0] shown;

    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [7:0]  din;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [8];

    sqrt_bcd_display #(.REFRESH_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .busy     (busy),
        .bcd      (bcd),
        .seg      (seg),
        .dig_en   (dig_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic void exp_disp(input logic [11:0] b, input int slot,
                                     output logic [2:0] de,
                                     output logic [6:0] sg);
        logic [3:0] n;
        logic       bl;
        n  = (slot == 0) ? b[3:0] : (slot == 1) ? b[7:4] : b[11:8];
        bl = (slot == 2 && b[11:8] == 4'h0) ||
             (slot == 1 && b[11:4] == 8'h00);
        de = bl ? 3'b000 : (3'b001 << slot);
        sg = bl ? 7'h00 : segtab[n];
    endfunction

    task automatic disp_one();
        logic [2:0] de;
        logic [6:0] sg;
        exp_disp(shown, (cyc / 4) % 3, de, sg);
        chk("dig_en", {29'd0, dig_en}, {29'd0, de});
        chk("seg", {25'd0, seg}, {25'd0, sg});
    endtask

    task automatic scan(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            disp_one();
        end
    endtask

    task automatic accept(input logic [7:0] d, input logic [11:0] e,
                          input bit align);
        int  k;
        bit  ok;
        k  = 0;
        ok = 1'b0;
        while (!ok && k < 30) begin
            @(negedge clk);
            k++;
            ok = in_ready && (!align || ((cyc / 4) % 3 == 2 && cyc % 4 == 0));
        end
        chk("accept_wait", {31'd0, ok}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_start", {31'd0, busy}, 32'd1);
        chk("ready_low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_hold", {31'd0, busy}, 32'd1);
            disp_one();
            if (i == 7) chk("bcd_old", {20'd0, bcd}, {20'd0, shown});
        end
        @(posedge clk);
        #1;
        chk("bcd_result", {20'd0, bcd}, {20'd0, e});
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("ready_done", {31'd0, in_ready}, 32'd1);
        shown = e;
        scan(12);
    endtask

    initial begin
        vecs[0] = '{8'd255, 12'h255};
        vecs[1] = '{8'd7,   12'h007};
        vecs[2] = '{8'd0,   12'h000};
        vecs[3] = '{8'd15,  12'h015};
        vecs[4] = '{8'd99,  12'h099};
        vecs[5] = '{8'd100, 12'h100};
        vecs[6] = '{8'd128, 12'h128};
        vecs[7] = '{8'd209, 12'h209};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        shown    = 12'h000;
        #3;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bcd", {20'd0, bcd}, 32'd0);
        chk("rst_dig", {29'd0, dig_en}, 32'd1);
        chk("rst_seg", {25'd0, seg}, 32'h3F);
        @(negedge clk);
        rst = 1'b0;
        scan(12);

        for (int v = 0; v < 8; v++) begin
            accept(vecs[v].din, vecs[v].exp, 1'b0);
        end

        // In-flight in_valid is ignored, then accepted at N+9.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd100;
        @(posedge clk);
        #1;
        in_data = 8'd42;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            disp_one();
            if (i == 7) chk("b2b_old", {20'd0, bcd}, {20'd0, shown});
        end
        @(posedge clk);
        #1;
        chk("b2b_first", {20'd0, bcd}, 32'h100);
        chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        shown = 12'h100;
        @(posedge clk);
        #1;
        chk("b2b_reaccept", {31'd0, busy}, 32'd1);
        in_valid = 1'b0;
        scan(7);
        @(posedge clk);
        #1;
        chk("b2b_hold", {20'd0, bcd}, 32'h100);
        @(posedge clk);
        #1;
        chk("b2b_second", {20'd0, bcd}, 32'h042);
        shown = 12'h042;
        scan(12);

        // Reset mid-conversion discards the partial result.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bcd", {20'd0, bcd}, 32'd0);
        chk("abort_dig", {29'd0, dig_en}, 32'd1);
        @(negedge clk);
        rst   = 1'b0;
        shown = 12'h000;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_after", {20'd0, bcd}, 32'd0);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        scan(12);

        // Accept during the hundreds slot; refresh keeps running.
        accept(8'd255, 12'h255, 1'b0);
        accept(8'd15, 12'h015, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
